// File: rtl/branch_target_buffer.sv
// branch_target_buffer
//   Direct-mapped branch target buffer with one 2-bit saturating direction
//   counter per entry. The fetch PC is looked up combinationally (zero
//   latency). Resolved branches and jumps train the table at the rising clock
//   edge.
//
// Ports
//   clk, rst           clock and synchronous active-high reset
//   if_pc              fetch PC to look up
//   pred_hit           a valid entry with a matching tag exists for if_pc
//   pred_taken         pred_hit and the counter MSB is set
//   pred_target        stored target when pred_hit, otherwise 0
//   upd_valid          a resolved control-transfer instruction is presented
//   upd_pc             PC of the resolved instruction
//   upd_taken          actual outcome
//   upd_uncond         instruction is jal/jalr
//   upd_target         actual target (bits [1:0] are not stored)
//   flush              invalidate every entry
module branch_target_buffer #(
  parameter int IDX_BITS = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_pc,
  output logic        pred_hit,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic        upd_uncond,
  input  logic [31:0] upd_target,
  input  logic        flush
);

  localparam int ENTRIES  = 1 << IDX_BITS;
  localparam int TAG_BITS = 30 - IDX_BITS;

  logic [ENTRIES-1:0]  valid_q, valid_d;
  logic [TAG_BITS-1:0] tag_q [ENTRIES];
  logic [TAG_BITS-1:0] tag_d [ENTRIES];
  logic [29:0]         tgt_q [ENTRIES];
  logic [29:0]         tgt_d [ENTRIES];
  logic [1:0]          ctr_q [ENTRIES];
  logic [1:0]          ctr_d [ENTRIES];

  function automatic logic [1:0] sat_inc(input logic [1:0] c);
    return (c == 2'b11) ? 2'b11 : c + 2'b01;
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] c);
    return (c == 2'b00) ? 2'b00 : c - 2'b01;
  endfunction

  // Lookup port: asynchronous read of the current (pre-edge) contents.
  logic [IDX_BITS-1:0] rd_idx;
  logic [TAG_BITS-1:0] rd_tag;
  logic                rd_hit;

  assign rd_idx      = if_pc[IDX_BITS+1:2];
  assign rd_tag      = if_pc[31:IDX_BITS+2];
  assign rd_hit      = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
  assign pred_hit    = rd_hit;
  assign pred_taken  = rd_hit && ctr_q[rd_idx][1];
  assign pred_target = rd_hit ? {tgt_q[rd_idx], 2'b00} : 32'h0;

  // Update port
  logic [IDX_BITS-1:0] wr_idx;
  logic [TAG_BITS-1:0] wr_tag;
  logic                wr_hit;

  assign wr_idx = upd_pc[IDX_BITS+1:2];
  assign wr_tag = upd_pc[31:IDX_BITS+2];
  assign wr_hit = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);

  // Byte-offset bits never participate in indexing, tagging or stored targets.
  logic unused_low_bits;
  assign unused_low_bits = ^{if_pc[1:0], upd_pc[1:0], upd_target[1:0]};

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    tgt_d   = tgt_q;
    ctr_d   = ctr_q;
    if (flush) begin
      valid_d = '0;
    end else if (upd_valid) begin
      if (wr_hit) begin
        if (upd_uncond) begin
          ctr_d[wr_idx] = 2'b11;
          tgt_d[wr_idx] = upd_target[31:2];
        end else if (upd_taken) begin
          ctr_d[wr_idx] = sat_inc(ctr_q[wr_idx]);
          tgt_d[wr_idx] = upd_target[31:2];
        end else begin
          ctr_d[wr_idx] = sat_dec(ctr_q[wr_idx]);
        end
      end else if (upd_taken) begin
        // Allocate, replacing whatever aliased into this slot.
        valid_d[wr_idx] = 1'b1;
        tag_d[wr_idx]   = wr_tag;
        tgt_d[wr_idx]   = upd_target[31:2];
        ctr_d[wr_idx]   = upd_uncond ? 2'b11 : 2'b10;
      end
    end
  end

  // Control state: valid bits and counters are reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= 2'b00;
    end else begin
      valid_q <= valid_d;
      ctr_q   <= ctr_d;
    end
  end

  // Payload state: meaningless while its valid bit is clear, so never reset.
  always_ff @(posedge clk) begin
    tag_q <= tag_d;
    tgt_q <= tgt_d;
  end

endmodule

// File: tb/tb_branch_target_buffer.sv
module tb_branch_target_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_pc;
  logic        pred_hit;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic        upd_uncond;
  logic [31:0] upd_target;
  logic        flush;

  int n_vec = 0;
  int n_err = 0;

  branch_target_buffer #(.IDX_BITS(5)) dut (
    .clk(clk), .rst(rst), .if_pc(if_pc),
    .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_uncond(upd_uncond), .upd_target(upd_target), .flush(flush)
  );

  always #5 clk = ~clk;

  // Reference model: a 32-slot table addressed by word address modulo 32,
  // keyed by the PC's upper bits, with counters kept as plain integers 0..3.
  bit          m_valid [32];
  int unsigned m_key   [32];
  int unsigned m_tgt   [32];
  int          m_ctr   [32];

  function automatic int unsigned slot_of(input logic [31:0] pc);
    return (pc / 4) % 32;
  endfunction

  function automatic int unsigned key_of(input logic [31:0] pc);
    return pc / 128;
  endfunction

  // Expected {hit, taken, target} for a lookup of pc.
  function automatic logic [33:0] m_lookup(input logic [31:0] pc);
    int unsigned s = slot_of(pc);
    bit hit = m_valid[s] && (m_key[s] == key_of(pc));
    if (!hit) return {1'b0, 1'b0, 32'h0};
    return {1'b1, (m_ctr[s] >= 2) ? 1'b1 : 1'b0, 32'(m_tgt[s])};
  endfunction

  task automatic model_edge();
    int unsigned s;
    bit hit;
    if (rst) begin
      for (int i = 0; i < 32; i++) begin m_valid[i] = 0; m_ctr[i] = 0; end
    end else if (flush) begin
      for (int i = 0; i < 32; i++) m_valid[i] = 0;
    end else if (upd_valid) begin
      s   = slot_of(upd_pc);
      hit = m_valid[s] && (m_key[s] == key_of(upd_pc));
      if (hit) begin
        if (upd_uncond) begin
          m_ctr[s] = 3; m_tgt[s] = upd_target & 32'hFFFF_FFFC;
        end else if (upd_taken) begin
          m_ctr[s] = (m_ctr[s] == 3) ? 3 : m_ctr[s] + 1;
          m_tgt[s] = upd_target & 32'hFFFF_FFFC;
        end else begin
          m_ctr[s] = (m_ctr[s] == 0) ? 0 : m_ctr[s] - 1;
        end
      end else if (upd_taken) begin
        m_valid[s] = 1; m_key[s] = key_of(upd_pc);
        m_tgt[s]   = upd_target & 32'hFFFF_FFFC;
        m_ctr[s]   = upd_uncond ? 3 : 2;
      end
    end
  endtask

  // One clock edge: model follows the DUT at the edge, inputs return to idle.
  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    rst = 1'b0; flush = 1'b0; upd_valid = 1'b0;
    upd_pc = 'x; upd_taken = 'x; upd_uncond = 'x; upd_target = 'x;
  endtask

  task automatic upd(input logic [31:0] pc, input logic tk, input logic un,
                     input logic [31:0] tg);
    upd_valid = 1'b1; upd_pc = pc; upd_taken = tk; upd_uncond = un; upd_target = tg;
    cycle();
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; upd_valid = 1'b0; if_pc = 32'h0000_1084;
    cycle(); rst = 1'b1; cycle();
    #1;
    n_vec++;
    if ({pred_hit, pred_taken, pred_target} !== {1'b0, 1'b0, 32'h0}) begin
      n_err++;
      $display("FAIL reset_cold_lookup: got hit=%b taken=%b tgt=%h, want 0 0 00000000",
               pred_hit, pred_taken, pred_target);
    end
  endtask

  task automatic test_alloc_warmup();
    logic [33:0] exp [5];
    exp[0] = {1'b1, 1'b1, 32'h0000_1000};  // after allocate (ctr 10)
    exp[1] = {1'b1, 1'b0, 32'h0000_1000};  // after two not-taken (ctr 00)
    exp[2] = {1'b1, 1'b1, 32'h0000_1000};  // after four taken (ctr 11)
    exp[3] = {1'b1, 1'b1, 32'h0000_1000};  // one not-taken (ctr 10)
    exp[4] = {1'b1, 1'b0, 32'h0000_1000};  // another not-taken (ctr 01)
    if_pc = 32'h0000_1084;
    for (int step = 0; step < 5; step++) begin
      case (step)
        0: upd(32'h0000_1084, 1'b1, 1'b0, 32'h0000_1000);
        1: begin upd(32'h0000_1084, 1'b0, 1'b0, 32'h0); upd(32'h0000_1084, 1'b0, 1'b0, 32'h0); end
        2: for (int k = 0; k < 4; k++) upd(32'h0000_1084, 1'b1, 1'b0, 32'h0000_1000);
        default: upd(32'h0000_1084, 1'b0, 1'b0, 32'h0);
      endcase
      #1;
      n_vec++;
      if ({pred_hit, pred_taken, pred_target} !== exp[step]) begin
        n_err++;
        $display("FAIL warmup_step%0d: got %b %b %h, want %b %b %h", step,
                 pred_hit, pred_taken, pred_target, exp[step][33], exp[step][32], exp[step][31:0]);
      end
    end
  endtask

  task automatic test_alias();
    upd(32'h0000_2084, 1'b1, 1'b1, 32'h0000_3000);
    if_pc = 32'h0000_1084; #1;
    n_vec++;
    if (pred_hit !== 1'b0) begin
      n_err++; $display("FAIL alias_old_evicted: got hit=%b, want 0", pred_hit);
    end
    if_pc = 32'h0000_2084; #1;
    n_vec++;
    if ({pred_hit, pred_taken, pred_target} !== {1'b1, 1'b1, 32'h0000_3000}) begin
      n_err++;
      $display("FAIL alias_new_entry: got %b %b %h, want 1 1 00003000",
               pred_hit, pred_taken, pred_target);
    end
  endtask

  task automatic test_not_taken_miss();
    upd(32'h0000_0040, 1'b0, 1'b0, 32'h0000_0800);
    if_pc = 32'h0000_0040; #1;
    n_vec++;
    if ({pred_hit, pred_taken, pred_target} !== {1'b0, 1'b0, 32'h0}) begin
      n_err++;
      $display("FAIL not_taken_miss: got %b %b %h, want 0 0 00000000",
               pred_hit, pred_taken, pred_target);
    end
  endtask

  task automatic test_same_cycle();
    flush = 1'b1; cycle();
    if_pc = 32'h0000_1084;
    upd_valid = 1'b1; upd_pc = 32'h0000_1084; upd_taken = 1'b1; upd_uncond = 1'b0;
    upd_target = 32'h0000_1000;
    #1;
    n_vec++;
    if (pred_hit !== 1'b0) begin
      n_err++; $display("FAIL same_cycle_no_bypass: got hit=%b, want 0", pred_hit);
    end
    cycle(); #1;
    n_vec++;
    if ({pred_hit, pred_taken, pred_target} !== {1'b1, 1'b1, 32'h0000_1000}) begin
      n_err++;
      $display("FAIL same_cycle_next: got %b %b %h, want 1 1 00001000",
               pred_hit, pred_taken, pred_target);
    end
  endtask

  task automatic test_flush();
    upd(32'h0000_2084, 1'b1, 1'b1, 32'h0000_3000);
    flush = 1'b1;
    upd(32'h0000_0040, 1'b1, 1'b0, 32'h0000_0800);
    for (int i = 0; i < 3; i++) begin
      if_pc = (i == 0) ? 32'h0000_2084 : (i == 1) ? 32'h0000_0040 : 32'h0000_1084;
      #1;
      n_vec++;
      if (pred_hit !== 1'b0) begin
        n_err++; $display("FAIL flush_pc%h: got hit=%b, want 0", if_pc, pred_hit);
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 3; k++) upd(32'h0000_1084, 1'b1, 1'b0, 32'h0000_1000);
    rst = 1'b1;
    upd(32'h0000_1084, 1'b1, 1'b0, 32'h0000_1000);
    if_pc = 32'h0000_1084; #1;
    n_vec++;
    if (pred_hit !== 1'b0) begin
      n_err++; $display("FAIL reset_mid_invalid: got hit=%b, want 0", pred_hit);
    end
    upd(32'h0000_1084, 1'b1, 1'b0, 32'h0000_1000);
    upd(32'h0000_1084, 1'b0, 1'b0, 32'h0);
    #1;
    // A fresh conditional allocation starts at ctr 10; one not-taken gives 01.
    n_vec++;
    if ({pred_hit, pred_taken} !== 2'b10) begin
      n_err++;
      $display("FAIL reset_mid_realloc: got hit=%b taken=%b, want 1 0", pred_hit, pred_taken);
    end
  endtask

  task automatic test_random();
    logic [33:0] exp;
    logic [31:0] pcs [6];
    pcs[0] = 32'h0000_1084; pcs[1] = 32'h0000_2084; pcs[2] = 32'h0000_1088;
    pcs[3] = 32'h0000_0008; pcs[4] = 32'hFFFF_FF8A; pcs[5] = 32'h0000_1101;
    for (int n = 0; n < 400; n++) begin
      if_pc = pcs[$urandom_range(5)];
      flush = ($urandom_range(39) == 0);
      rst   = ($urandom_range(99) == 0);
      upd_valid = ($urandom_range(3) != 0);
      if (upd_valid) begin
        upd_pc     = pcs[$urandom_range(5)];
        upd_uncond = ($urandom_range(3) == 0);
        upd_taken  = upd_uncond ? 1'b1 : 1'($urandom_range(1));
        upd_target = $urandom;
      end
      #1;
      exp = m_lookup(if_pc);
      n_vec++;
      if ({pred_hit, pred_taken, pred_target} !== exp) begin
        n_err++;
        $display("FAIL random_%0d pc=%h: got %b %b %h, want %b %b %h", n, if_pc,
                 pred_hit, pred_taken, pred_target, exp[33], exp[32], exp[31:0]);
      end
      cycle();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; flush = 1'b0; upd_valid = 1'b0; if_pc = 32'h0;
    upd_pc = 'x; upd_taken = 'x; upd_uncond = 'x; upd_target = 'x;
    test_reset();
    test_alloc_warmup();
    test_alias();
    test_not_taken_miss();
    test_same_cycle();
    test_flush();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
